// File: rtl/barrier_unshift_stream_pkg.sv
// barrier_pkg: shared constants, occupancy encoding and rotate helpers for
// the barrier un-shift stream.
//   DATA_W / SHIFT_W : word width and shift-amount width the helpers work on
//   DIR_LEFT/RIGHT   : direction tag carried with each rotated word
//   occ_e            : output-buffer occupancy (EMPTY / ONE / FULL)
//   rotl / rotr      : rotate a DATA_W word by a SHIFT_W amount
package barrier_pkg;

  localparam int DATA_W  = 4;
  localparam int SHIFT_W = $clog2(DATA_W);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Rotate via a doubled word: the bits shifted out of one copy are the
  // bits shifted into the other, so a plain shift of {w,w} is a rotate.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] word,
                                             input logic [SHIFT_W-1:0] amt);
    logic [2*DATA_W-1:0] tmp;
    tmp = {word, word} << amt;
    return tmp[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] word,
                                             input logic [SHIFT_W-1:0] amt);
    logic [2*DATA_W-1:0] tmp;
    tmp = {word, word} >> amt;
    return tmp[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/barrier_unshift_stream_if.sv
// barrier_unshift_stream_if: bundles both handshakes of the un-shift stream.
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1; valid, data, shift and dir must stay stable until
// that edge, and ready never depends combinationally on valid.
//   in_valid/in_ready/in_data/in_shift/in_dir : rotated-token input side
//   out_valid/out_ready/out_data              : recovered-word output side
//   tok_count : tokens accepted since reset
//   occ       : buffer occupancy state (debug visibility)
// master = producer/consumer environment, slave = the un-shift block.
interface barrier_unshift_stream_if
  import barrier_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHIFT_W,
  parameter int CNTW  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shift;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNTW-1:0]  tok_count;
  occ_e             occ;

  modport master (
    output in_valid, in_data, in_shift, in_dir, out_ready,
    input  in_ready, out_valid, out_data, tok_count, occ
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_dir, out_ready,
    output in_ready, out_valid, out_data, tok_count, occ
  );
endinterface

// File: rtl/barrier_unshift_stream_unrotate.sv
// barrier_unrotate: combinational inverse of the barrier rotator.
//   data  : rotated word
//   shift : amount it was rotated by
//   dir   : DIR_LEFT if it was rotated left, DIR_RIGHT if rotated right
//   word  : recovered original word
module barrier_unrotate
  import barrier_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHIFT_W
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shift,
  input  logic             dir,
  output logic [WIDTH-1:0] word
);
  // Undo by rotating the opposite way by the same amount.
  assign word = (dir == DIR_LEFT) ? rotr(data, shift) : rotl(data, shift);
endmodule

// File: rtl/barrier_unshift_stream.sv
// barrier_unshift_stream: accepts rotated tokens, un-rotates them and holds
// the recovered words in a 2-entry FIFO for the consumer.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : barrier_unshift_stream_if.slave (input/output handshakes,
//         tok_count, occupancy debug state)
module barrier_unshift_stream
  import barrier_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = SHIFT_W,
  parameter int CNTW  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  barrier_unshift_stream_if.slave   bus
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [CNTW-1:0]  cnt_q;
  logic [WIDTH-1:0] word;
  logic             push;
  logic             pop;

  barrier_unrotate #(.WIDTH(WIDTH), .SHW(SHW)) u_unrotate (
    .data  (bus.in_data),
    .shift (bus.in_shift),
    .dir   (bus.in_dir),
    .word  (word)
  );

  // Both flags come from registered state only, so out_ready never reaches
  // in_ready combinationally.
  assign bus.in_ready  = (state_q != OCC_FULL);
  assign bus.out_valid = (state_q != OCC_EMPTY);
  assign bus.out_data  = head_q;
  assign bus.tok_count = cnt_q;
  assign bus.occ       = state_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // head_q is a dedicated register rather than mem_q[rd_ptr_q] so that after
  // the last pop it keeps showing the popped word instead of a stale slot.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          state_d = OCC_ONE;
          head_d  = word;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = word;
        end else if (push) begin
          state_d = OCC_FULL;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          state_d = OCC_ONE;
          head_d  = mem_q[~rd_ptr_q];
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OCC_EMPTY;
      head_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      if (push) begin
        mem_q[wr_ptr_q] <= word;
        wr_ptr_q        <= ~wr_ptr_q;
        cnt_q           <= cnt_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_barrier_unshift_stream.sv
// tb_barrier_unshift_stream: directed vectors plus hand-written sequences
// for reset, backpressure, streaming and an exhaustive un-rotate sweep.
module tb_barrier_unshift_stream;
  import barrier_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_cnt;
  logic [3:0] exp_q[$];

  barrier_unshift_stream_if #(.WIDTH(4), .SHW(2), .CNTW(16)) bus ();

  barrier_unshift_stream #(.WIDTH(4), .SHW(2), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [1:0] shift;
    logic       dir;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[10];

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Forward rotator built one bit-step at a time.
  function automatic logic [3:0] rot_fwd(input logic [3:0] w, input int s, input logic d);
    logic [3:0] r;
    r = w;
    for (int k = 0; k < s; k++)
      r = (d == 1'b0) ? {r[2:0], r[3]} : {r[0], r[3:1]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s, input logic dr);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_shift = s;
    bus.in_dir   = dr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'h0, 2'd0, 1'b0);
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_cnt = 0;
    rst = 1'b1;
    drive(1'b0, 4'h0, 2'd0, 1'b0);
    bus.out_ready = 1'b0;

    vecs[0] = '{4'b0111, 2'd1, 1'b0, 4'b1011};
    vecs[1] = '{4'b1101, 2'd1, 1'b1, 4'b1011};
    vecs[2] = '{4'b1110, 2'd2, 1'b0, 4'b1011};
    vecs[3] = '{4'b1110, 2'd2, 1'b1, 4'b1011};
    vecs[4] = '{4'b1000, 2'd0, 1'b0, 4'b1000};
    vecs[5] = '{4'b0110, 2'd0, 1'b1, 4'b0110};
    vecs[6] = '{4'b0001, 2'd3, 1'b0, 4'b0010};
    vecs[7] = '{4'b0001, 2'd3, 1'b1, 4'b1000};
    vecs[8] = '{4'b1100, 2'd1, 1'b0, 4'b0110};
    vecs[9] = '{4'b0011, 2'd2, 1'b1, 4'b1100};

    // ---------------- initial reset ----------------
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_tok_count", 32'(bus.tok_count), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // ---------------- reset while FULL ----------------
    bus.out_ready = 1'b0;
    drive(1'b1, 4'h3, 2'd0, 1'b0);
    step();
    drive(1'b1, 4'h9, 2'd0, 1'b0);
    step();
    drive(1'b0, 4'h0, 2'd0, 1'b0);
    chk("full_occ", 32'(bus.occ), 32'(OCC_FULL));
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_out_data", 32'(bus.out_data), 32'd0);
    chk("async_tok_count", 32'(bus.tok_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- table vectors ----------------
    bus.out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].data, vecs[i].shift, vecs[i].dir);
      exp_cnt++;
      step();
      drive(1'b0, 4'h0, 2'd0, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp));
      step();
    end
    chk("vec_tok_count", 32'(bus.tok_count), 32'(exp_cnt));
    chk("vec_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("vec_hold_last", 32'(bus.out_data), 32'(vecs[9].exp));

    // ---------------- backpressure ----------------
    bus.out_ready = 1'b0;
    drive(1'b1, 4'hA, 2'd0, 1'b0);
    exp_cnt++;
    step();
    chk("bp_first_head", 32'(bus.out_data), 32'hA);
    chk("bp_ready_one", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 4'h5, 2'd0, 1'b0);
    exp_cnt++;
    step();
    chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_occ_full", 32'(bus.occ), 32'(OCC_FULL));
    drive(1'b1, 4'h3, 2'd0, 1'b0);
    step();
    chk("bp_third_dropped", 32'(bus.tok_count), 32'(exp_cnt));
    chk("bp_head_held", 32'(bus.out_data), 32'hA);
    drive(1'b0, 4'h0, 2'd0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_second_data", 32'(bus.out_data), 32'h5);
    step();
    chk("bp_drained_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_drained_hold", 32'(bus.out_data), 32'h5);

    // ---------------- push+pop in ONE ----------------
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] w;
      if (k > 0) begin
        chk($sformatf("pp%0d_occ", k), 32'(bus.occ), 32'(OCC_ONE));
        chk($sformatf("pp%0d_valid", k), 32'(bus.out_valid), 32'd1);
        chk($sformatf("pp%0d_data", k), 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
      w = 4'((k * 3 + 1) % 16);
      exp_q.push_back(w);
      drive(1'b1, rot_fwd(w, k % 4, 1'(k % 2)), 2'(k % 4), 1'(k % 2));
      step();
    end
    drive(1'b0, 4'h0, 2'd0, 1'b0);
    chk("pp_last_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
    step();
    chk("pp_empty", 32'(bus.out_valid), 32'd0);
    chk("pp_tok_count", 32'(bus.tok_count), 32'd10);
    chk("pp_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- exhaustive sweep ----------------
    do_reset();
    bus.out_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      for (int s = 0; s < 4; s++) begin
        for (int d = 0; d < 2; d++) begin
          if (exp_q.size() != 0)
            chk("exh", {27'd0, bus.out_valid, bus.out_data}, {27'd0, 1'b1, exp_q.pop_front()});
          exp_q.push_back(4'(w));
          drive(1'b1, rot_fwd(4'(w), s, 1'(d)), 2'(s), 1'(d));
          step();
        end
      end
    end
    drive(1'b0, 4'h0, 2'd0, 1'b0);
    chk("exh", {27'd0, bus.out_valid, bus.out_data}, {27'd0, 1'b1, exp_q.pop_front()});
    step();
    chk("exh_tok_count", 32'(bus.tok_count), 32'd128);
    chk("exh_empty", 32'(bus.out_valid), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
